// File: rtl/hazard_if.sv
// Hazard unit bundle: ID-stage instruction info and MEM branch result toward the
// hazard unit, stall/flush/bypass/forwarding controls and perf counters back.
interface hazard_if #(
   parameter int REG_NUM_WIDTH = 5,
   parameter int CNT_WIDTH     = 16
);
   logic                     idValid;
   logic [REG_NUM_WIDTH-1:0] idRs;
   logic [REG_NUM_WIDTH-1:0] idRt;
   logic                     idUsesRs;
   logic                     idUsesRt;
   logic [REG_NUM_WIDTH-1:0] idWrNum;
   logic                     idRegWrite;
   logic                     idMemRead;
   logic                     brTaken;
   logic                     stall;
   logic                     flush;
   logic                     idBypassS;
   logic                     idBypassT;
   logic [1:0]               exFwdS;
   logic [1:0]               exFwdT;
   logic [CNT_WIDTH-1:0]     stallCount;
   logic [CNT_WIDTH-1:0]     flushCount;

   modport master (
      output idValid, idRs, idRt, idUsesRs, idUsesRt, idWrNum, idRegWrite, idMemRead, brTaken,
      input  stall, flush, idBypassS, idBypassT, exFwdS, exFwdT, stallCount, flushCount
   );

   modport slave (
      input  idValid, idRs, idRt, idUsesRs, idUsesRt, idWrNum, idRegWrite, idMemRead, brTaken,
      output stall, flush, idBypassS, idBypassT, exFwdS, exFwdT, stallCount, flushCount
   );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage pipeline: in-flight write scoreboard, ID stall, branch flush,
// EX forwarding selects and saturating perf counters. Build option: FORWARDING_EN.
module hazard_unit #(
   parameter int REG_NUM_WIDTH = 5,
   parameter int CNT_WIDTH     = 16
) (
   input  logic     clk,
   input  logic     rst,
   hazard_if.slave  hz
);
   localparam int NREG = 2 ** REG_NUM_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // age: 0 = idle, 1 = producer in EX, 2 = in MEM, 3 = in WB
   logic [NREG-1:0][1:0] age;
   logic [1:0]           age_s;
   logic [1:0]           age_t;
   logic                 haz_s;
   logic                 haz_t;
   logic                 stall_cond;
   logic                 issue;
   logic [CNT_WIDTH-1:0] stall_cnt;
   logic [CNT_WIDTH-1:0] flush_cnt;

   assign age_s = age[hz.idRs];
   assign age_t = age[hz.idRt];
   assign haz_s = hz.idUsesRs && (hz.idRs != '0) && (age_s != 2'd0);
   assign haz_t = hz.idUsesRt && (hz.idRt != '0) && (age_t != 2'd0);

`ifdef FORWARDING_EN
   logic [NREG-1:0] is_load;
   logic            load_s;
   logic            load_t;
   logic [1:0]      ex_fwd_s;
   logic [1:0]      ex_fwd_t;

   assign load_s = is_load[hz.idRs];
   assign load_t = is_load[hz.idRt];

   // Only a load still in EX cannot be forwarded in time.
   assign stall_cond = (haz_s && (age_s == 2'd1) && load_s) ||
                       (haz_t && (age_t == 2'd1) && load_t);

   function automatic logic [1:0] fwd_sel(input logic [1:0] a, input logic ld);
      logic [1:0] sel;
      sel = 2'd0;
      if (a == 2'd1 && !ld) sel = 2'd1;
      else if (a == 2'd2)   sel = 2'd2;
      return sel;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         is_load <= '0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (issue && hz.idRegWrite && (hz.idWrNum == REG_NUM_WIDTH'(r)))
               is_load[r] <= hz.idMemRead;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_fwd_s <= 2'd0;
         ex_fwd_t <= 2'd0;
      end else if (issue) begin
         ex_fwd_s <= fwd_sel(age_s, load_s);
         ex_fwd_t <= fwd_sel(age_t, load_t);
      end else begin
         ex_fwd_s <= 2'd0;
         ex_fwd_t <= 2'd0;
      end
   end

   // WB writes at this edge, so the register file read in ID is stale.
   assign hz.idBypassS = hz.idUsesRs && (hz.idRs != '0) && (age_s == 2'd3) && !rst;
   assign hz.idBypassT = hz.idUsesRt && (hz.idRt != '0) && (age_t == 2'd3) && !rst;
   assign hz.exFwdS    = ex_fwd_s;
   assign hz.exFwdT    = ex_fwd_t;
`else
   assign stall_cond   = haz_s || haz_t;
   assign hz.idBypassS = 1'b0;
   assign hz.idBypassT = 1'b0;
   assign hz.exFwdS    = 2'd0;
   assign hz.exFwdT    = 2'd0;
`endif

   assign hz.flush = hz.brTaken & ~rst;
   assign hz.stall = hz.idValid & ~hz.flush & ~rst & stall_cond;
   assign issue    = hz.idValid & ~hz.stall & ~hz.flush;

   // A new writer overrides aging; on flush the squashed EX producer is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         age <= '0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (issue && hz.idRegWrite && (hz.idWrNum == REG_NUM_WIDTH'(r)))
               age[r] <= 2'd1;
            else if (hz.flush && (age[r] == 2'd1))
               age[r] <= 2'd0;
            else if (age[r] != 2'd0)
               age[r] <= age[r] + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hz.stall && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
         if (hz.flush && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
   end

   assign hz.stallCount = stall_cnt;
   assign hz.flushCount = flush_cnt;
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard unit for the five-stage pipeline (IF, ID, EX, MEM, WB). It keeps a per-register scoreboard of in-flight writes and decides when ID must stall. It generates the squash pulse when a branch resolves taken in MEM, and drives the operand-forwarding selects for EX. It also keeps saturating stall and flush counters for performance measurement.

## Interface
Parameters:
- REG_NUM_WIDTH, 5, register number width; the register file has 2**REG_NUM_WIDTH entries, and register 0 is hard-wired zero.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- idValid  in  1  ID holds a real instruction.
- idRs / idRt  in  REG_NUM_WIDTH  source register numbers.
- idUsesRs / idUsesRt  in  1  source is actually read.
- idWrNum  in  REG_NUM_WIDTH  destination register (after RegDst mux).
- idRegWrite  in  1  instruction writes a register.
- idMemRead  in  1  instruction is a load.
- brTaken  in  1  branch in MEM resolved taken this cycle.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX (combinational).
- flush  out  1  squash IF/ID, ID/EX and EX/MEM contents this cycle (combinational).
- idBypassS / idBypassT  out  1  latch WB write data into ID/EX instead of the register file read (combinational).
- exFwdS / exFwdT  out  2  EX operand source: 0 = ID/EX value, 1 = EX/MEM ALU result, 2 = MEM/WB write data (registered).
- stallCount / flushCount  out  CNT_WIDTH  saturating event counters.

## Operation
Scoreboard
- Each register r > 0 has a 2-bit age field (0 = no pending write; 1 = producer in EX; 2 = in MEM; 3 = in WB) and one isLoad bit.
- Every cycle, each nonzero age increments. Age 3 becomes 0.
- Issue is `idValid & !stall & !flush`.
- On issue with idRegWrite and idWrNum != 0, the entry for idWrNum becomes age 1 with isLoad = idMemRead. This write has priority over aging.
- Only the newest writer of a register is tracked.

Source hazard
- A source src is hazardous if its use bit is set, src != 0, and age[src] != 0.

Stall
- With FORWARDING_EN, stall when a hazardous source has age 1 and isLoad set (load-use).
- Without FORWARDING_EN, stall on any hazardous source.
- stall is always gated by idValid & !flush & !rst.

Flush
- flush = brTaken & !rst.
- On flush, the ID instruction is not issued and stall is forced to 0, so the PC takes the branch target.
- Entries at age 1 (the squashed EX instruction) are cleared instead of advancing. All other entries age normally.

Forwarding (FORWARDING_EN only)
- At issue, for each source, exFwd is loaded from the producer's age: age 1 (non-load) gives 1; age 2 gives 2; any other age gives 0.
- idBypass is 1 when the producer is at age 3, because WB writes at this edge and the register file read is stale.
- When not issuing, exFwd loads 0.

Counters
- stallCount increments on each cycle with stall = 1.
- flushCount increments on each cycle with flush = 1.
- Both saturate at all-ones.

## Timing
- Reset values: all ages 0, all isLoad 0, exFwdS/T 0, stallCount/flushCount 0. stall, flush and idBypass read 0 while rst is high.
- Reset asserted mid-stall: the scoreboard is empty on the next cycle, and a held instruction issues without a stall.
- stall, flush and idBypass depend combinationally on the ID inputs, brTaken and registered state; there are no combinational paths from exFwd.
- exFwd is valid in the cycle after issue, i.e. while the consumer is in EX.
- Load-use with forwarding costs exactly 1 bubble. Without forwarding, a dependency at distance 1 costs 3 bubbles.
- brTaken together with a stall condition: flush wins, stall = 0, and nothing is inserted.

## Configuration
- FORWARDING_EN defined: load-use-only stalls, and idBypass/exFwd are active as described in Operation.
- FORWARDING_EN undefined: stall on every pending source, exFwdS/T are tied to 0, idBypassS/T are tied to 0, and the forwarding logic is not compiled.

## Test plan
- FORWARDING_EN, issue add r1, then add r2,r1 with idUsesRs -> stall 0; the next cycle exFwdS = 1.
- FORWARDING_EN, issue lw r3, then add r4,r3 (idUsesRt) -> stall = 1 for exactly 1 cycle; after issue exFwdT = 2; stallCount = 1.
- FORWARDING_EN, issue add r6, then two independent instructions, then a reader of r6 -> stall 0, idBypassS = 1 in the issue cycle.
- No FORWARDING_EN, issue add r1, then add r2,r1 -> stall = 1 for 3 cycles, issue on the 4th cycle, exFwd = 0 throughout.
- Writer of r5 at age 1, ID reads r5 with a load pending stall, brTaken = 1 -> flush 1, stall 0, age[r5] = 0 the next cycle, flushCount increments by 1.
- Write r0, then read r0 -> no stall; assert rst during a 3-cycle stall -> all ages, exFwd and counters are 0 the next cycle.
